// File: rtl/mod_mul_q_pipe_pkg.sv
// Shared constants for the q = 8380417 modular multiplier: modulus, widths and fold sizing.
`timescale 1ns/1ps
package mod_mul_q_pipe_pkg;

  localparam int          DIL_W      = 23;
  localparam logic [22:0] DIL_Q      = 23'd8380417;
  localparam int          FOLD_SHIFT = 13;

  // Bound after each fold: 46 -> 37 -> 28 -> 24 bits.
  localparam int PROD_W = 2 * DIL_W;
  localparam int F1_W   = 37;
  localparam int F2_W   = 28;
  localparam int F3_W   = DIL_W + 1;

  localparam int STAGES = 5;

endpackage

// File: rtl/mod_q_fold.sv
// One reduction step using 2^23 = 2^13 - 1 (mod q): x -> (x >> 23) * (2^13 - 1) + x[22:0].
`timescale 1ns/1ps
module mod_q_fold
  import mod_mul_q_pipe_pkg::*;
#(
  parameter int IN_W  = 46,
  parameter int OUT_W = 37
) (
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] y
);

  logic [OUT_W-1:0] hi;
  logic [OUT_W-1:0] lo;

  assign hi = OUT_W'(x[IN_W-1:DIL_W]);
  assign lo = OUT_W'(x[DIL_W-1:0]);

  // Shift-subtract instead of a constant multiply; OUT_W always covers hi << 13.
  assign y = (hi << FOLD_SHIFT) - hi + lo;

endmodule

// File: rtl/mod_mul_q_pipe.sv
// Five-stage pipelined (a*b) mod 8380417 with a tag carried alongside each product.
`timescale 1ns/1ps
module mod_mul_q_pipe
  import mod_mul_q_pipe_pkg::*;
#(
  parameter int W       = DIL_W,
  parameter int TAG_W   = 8,
  parameter int LATENCY = STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [W-1:0]     opa,
  input  logic [W-1:0]     opb,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [W-1:0]     mul_result,
  output logic [TAG_W-1:0] out_tag
);

  // Final correction: input is < 2^24, so at most two subtractions of q.
  function automatic logic [W-1:0] reduce_q(input logic [F3_W-1:0] x);
    logic signed [F3_W+1:0] d;
    logic        [F3_W-1:0] r;
    r = x;
    for (int i = 0; i < 2; i++) begin
      d = signed'({2'b00, r}) - signed'({2'b00, F3_W'(DIL_Q)});
      if (!d[F3_W+1]) r = F3_W'(d);
    end
    return r[W-1:0];
  endfunction

  logic [W-1:0]      a_p1, b_p1;
  logic [PROD_W-1:0] prod_p2;
  logic [F1_W-1:0]   f1_p3;
  logic [F3_W-1:0]   f3_p4;
  logic [W-1:0]      res_p5;

  logic             vld_p1, vld_p2, vld_p3, vld_p4, vld_p5;
  logic [TAG_W-1:0] tag_p1, tag_p2, tag_p3, tag_p4, tag_p5;

  logic [F1_W-1:0] f1_c;
  logic [F2_W-1:0] f2_c;
  logic [F3_W-1:0] f3_c;

  mod_q_fold #(.IN_W(PROD_W), .OUT_W(F1_W)) u_fold1 (.x(prod_p2), .y(f1_c));
  mod_q_fold #(.IN_W(F1_W),   .OUT_W(F2_W)) u_fold2 (.x(f1_p3),   .y(f2_c));
  mod_q_fold #(.IN_W(F2_W),   .OUT_W(F3_W)) u_fold3 (.x(f2_c),    .y(f3_c));

  always_ff @(posedge clk) begin
    if (rst) begin
      a_p1    <= '0;
      b_p1    <= '0;
      prod_p2 <= '0;
      f1_p3   <= '0;
      f3_p4   <= '0;
      res_p5  <= '0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      vld_p3  <= 1'b0;
      vld_p4  <= 1'b0;
      vld_p5  <= 1'b0;
      tag_p1  <= '0;
      tag_p2  <= '0;
      tag_p3  <= '0;
      tag_p4  <= '0;
      tag_p5  <= '0;
    end else if (en) begin
      // S1: capture operands
      a_p1    <= opa;
      b_p1    <= opb;
      vld_p1  <= in_valid;
      tag_p1  <= in_tag;
      // S2: full product
      prod_p2 <= PROD_W'(a_p1) * PROD_W'(b_p1);
      vld_p2  <= vld_p1;
      tag_p2  <= tag_p1;
      // S3: first fold
      f1_p3   <= f1_c;
      vld_p3  <= vld_p2;
      tag_p3  <= tag_p2;
      // S4: second and third fold
      f3_p4   <= f3_c;
      vld_p4  <= vld_p3;
      tag_p4  <= tag_p3;
      // S5: final correction into [0, q-1]
      res_p5  <= reduce_q(f3_p4);
      vld_p5  <= vld_p4;
      tag_p5  <= tag_p4;
    end
  end

  assign out_valid  = vld_p5;
  assign mul_result = res_p5;
  assign out_tag    = tag_p5;

endmodule
